// File: rtl/muldiv_hilo_pkg.sv
// Shared ALU operation codes, divider FSM states and iteration constants
// used by the HI/LO multiply/divide unit and its divider datapath.
package muldiv_hilo_pkg;

  localparam logic [4:0] ALU_NOP           = 5'd0;
  localparam logic [4:0] ALU_SIGNED_MULT   = 5'd14;
  localparam logic [4:0] ALU_UNSIGNED_MULT = 5'd15;
  localparam logic [4:0] ALU_SIGNED_DIV    = 5'd16;
  localparam logic [4:0] ALU_UNSIGNED_DIV  = 5'd17;
  localparam logic [4:0] ALU_MFHI          = 5'd18;
  localparam logic [4:0] ALU_MFLO          = 5'd19;
  localparam logic [4:0] ALU_MTHI          = 5'd20;
  localparam logic [4:0] ALU_MTLO          = 5'd21;

  localparam int DIV_ITERS = 32;
  localparam int DIV_CNT_W = $clog2(DIV_ITERS);

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  // Absolute value for signed operands; 0x80000000 maps onto itself, which is
  // exactly the unsigned magnitude it represents.
  function automatic logic [31:0] magnitude(input logic [31:0] value, input logic signed_op);
    return (signed_op && value[31]) ? (32'd0 - value) : value;
  endfunction

endpackage

// File: rtl/div_radix2.sv
// Unsigned restoring radix-2 divider datapath: one quotient bit per step,
// operands latched on load, iteration counter exposed to the controlling FSM.
module div_radix2
  import muldiv_hilo_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        last
);

  logic [31:0]          quo;
  logic [31:0]          rem;
  logic [31:0]          dvs;
  logic [DIV_CNT_W-1:0] count;
  logic [32:0]          partial;
  logic [32:0]          diff;

  // Bit 32 of the difference is the borrow: set means the trial subtract failed.
  assign partial = {rem, quo[31]};
  assign diff    = partial - {1'b0, dvs};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo   <= '0;
      rem   <= '0;
      dvs   <= '0;
      count <= '0;
    end else if (load) begin
      quo   <= dividend;
      rem   <= '0;
      dvs   <= divisor;
      count <= '0;
    end else if (step) begin
      if (!diff[32]) begin
        rem <= diff[31:0];
        quo <= {quo[30:0], 1'b1};
      end else begin
        rem <= partial[31:0];
        quo <= {quo[30:0], 1'b0};
      end
      count <= count + 1'b1;
    end
  end

  assign quotient  = quo;
  assign remainder = rem;
  assign last      = (count == DIV_CNT_W'(DIV_ITERS - 1));

endmodule

// File: rtl/muldiv_hilo.sv
// HI/LO register file with single-cycle multiply, MTHI/MTLO, and a 32-step
// iterative divide that stalls the front of the pipeline while it runs.
module muldiv_hilo
  import muldiv_hilo_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  alu_control,
  input  logic        valid,
  input  logic        flush,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        stall,
  output logic [31:0] hilo_rdata,
  output logic [31:0] hi_q,
  output logic [31:0] lo_q
);

  div_state_t  state, state_next;
  logic        signed_div, is_div, start_div, div_load, div_step, div_last;
  logic        neg_quo, neg_rem;
  logic [31:0] quo_mag, rem_mag, quo_res, rem_res;
  logic [63:0] a_sext, b_sext, prod_signed, prod_unsigned;

  assign signed_div = (alu_control == ALU_SIGNED_DIV);
  assign is_div     = signed_div || (alu_control == ALU_UNSIGNED_DIV);
  assign start_div  = valid && !flush && is_div && (src_b != 32'd0);
  assign div_load   = (state == DIV_IDLE) && start_div;
  assign div_step   = (state == DIV_BUSY);

  div_radix2 u_div (
    .clk       (clk),
    .rst       (rst),
    .load      (div_load),
    .step      (div_step),
    .dividend  (magnitude(src_a, signed_div)),
    .divisor   (magnitude(src_b, signed_div)),
    .quotient  (quo_mag),
    .remainder (rem_mag),
    .last      (div_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg_quo <= 1'b0;
      neg_rem <= 1'b0;
    end else if (div_load) begin
      neg_quo <= signed_div && (src_a[31] ^ src_b[31]);
      neg_rem <= signed_div && src_a[31];
    end
  end

  assign quo_res = neg_quo ? (32'd0 - quo_mag) : quo_mag;
  assign rem_res = neg_rem ? (32'd0 - rem_mag) : rem_mag;

  // Low 64 bits of a 64x64 product of sign-extended operands is the signed product.
  assign a_sext        = {{32{src_a[31]}}, src_a};
  assign b_sext        = {{32{src_b[31]}}, src_b};
  assign prod_signed   = a_sext * b_sext;
  assign prod_unsigned = {32'd0, src_a} * {32'd0, src_b};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= DIV_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    case (state)
      DIV_IDLE: begin
        if (start_div) begin
          state_next = DIV_BUSY;
          stall      = 1'b1;
        end
      end
      DIV_BUSY: begin
        stall = 1'b1;
        if (div_last) state_next = DIV_DONE;
      end
      DIV_DONE: state_next = DIV_IDLE;
      default:  state_next = DIV_IDLE;
    endcase
    if (flush || rst) begin
      state_next = DIV_IDLE;
      stall      = 1'b0;
    end
  end

  // Divide results land from DONE; all other writers only act from IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (!flush) begin
      if (state == DIV_DONE) begin
        hi_q <= rem_res;
        lo_q <= quo_res;
      end else if (state == DIV_IDLE && valid) begin
        case (alu_control)
          ALU_SIGNED_MULT:   {hi_q, lo_q} <= prod_signed;
          ALU_UNSIGNED_MULT: {hi_q, lo_q} <= prod_unsigned;
          ALU_MTHI:          hi_q <= src_a;
          ALU_MTLO:          lo_q <= src_a;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    hilo_rdata = 32'd0;
    if (alu_control == ALU_MFHI)      hilo_rdata = hi_q;
    else if (alu_control == ALU_MFLO) hilo_rdata = lo_q;
  end

endmodule

// File: doc/muldiv_hilo.md
MULDIV_HILO -- requirements
Module: muldiv_hilo

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 alu_control  input  5  EX-stage operation code, using the ALU_* codes of aludefines.vh.
REQ-004 valid  input  1  EX-stage instruction is live; no operation starts or writes HI/LO when low.
REQ-005 flush  input  1  cancel the EX-stage instruction (exception or redirect).
REQ-006 src_a  input  32  rs operand: dividend or multiplicand, or MTHI/MTLO data.
REQ-007 src_b  input  32  rt operand: divisor or multiplier.
REQ-008 stall  output  1  hold the pipeline from IF through EX while a divide is in progress.
REQ-009 hilo_rdata  output  32  HI for ALU_MFHI, LO for ALU_MFLO, 0 otherwise; combinational from the registers.
REQ-010 hi_q / lo_q  output  32 each  current HI/LO register contents.

Function
REQ-011 ALU_SIGNED_MULT and ALU_UNSIGNED_MULT, with valid=1 and flush=0, SHALL write the 64-bit product as {HI,LO} at the next edge, with no stall.
REQ-012 ALU_MTHI / ALU_MTLO, with valid=1, flush=0 and stall=0, SHALL write src_a to HI / LO at the next edge; the other register is unchanged.
REQ-013 Divide FSM states: IDLE, BUSY, DONE.
REQ-014 IDLE->BUSY SHALL occur when valid=1, flush=0, alu_control is ALU_SIGNED_DIV or ALU_UNSIGNED_DIV, and src_b!=0.
  - On that transition, latch |src_a|, |src_b| (raw values if unsigned) and both operand signs.
  - Clear the iteration counter.
REQ-015 stall SHALL be asserted combinationally in the IDLE cycle that meets the REQ-014 start condition, and in every BUSY cycle; 0 in IDLE otherwise and in DONE.
REQ-016 BUSY SHALL run one restoring radix-2 step per cycle for exactly 32 cycles, with the counter running 0..31, then go to DONE.
REQ-017 DONE SHALL write LO=quotient and HI=remainder at its edge, then go to IDLE; a start condition present in DONE SHALL be ignored.
REQ-018 Issue-to-result timing: stall is high for exactly 33 cycles; HI/LO are updated at the end of cycle 34.
REQ-019 Signed result correction:
  - quotient is negated when the operand signs differ;
  - remainder takes the sign of the dividend.
REQ-020 Signed 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0 (two's-complement wrap).
REQ-021 A divisor of 0 SHALL leave HI/LO unchanged, assert no stall, and not leave IDLE.
REQ-022 flush=1 in any state SHALL force IDLE at the next edge, suppress every pending HI/LO write, and drive stall=0 combinationally.
REQ-023 Priority: flush > divide write in DONE > mult/MTHI/MTLO write.
  - Mult/MTHI/MTLO writes are blocked whenever the FSM is not in IDLE.
REQ-024 All other alu_control codes SHALL leave HI, LO and the FSM unchanged.

Reset
REQ-025 rst=1 SHALL immediately set: FSM=IDLE, counter=0, HI=0, LO=0, stall=0, all divider datapath registers=0.
REQ-026 rst asserted mid-division SHALL abort the divide with no HI/LO write; after release the block accepts a new operation in the first cycle.

Structure
REQ-027 FSM state encodings and the iteration-count constant (32) SHALL be defined in the shared defines header alongside aludefines.vh.
REQ-028 The iterative divider datapath (operand registers, partial remainder, quotient shift, counter) SHALL be one sub-module, div_radix2.
  - muldiv_hilo owns the FSM, sign handling, multiplier and HI/LO registers.

Verification
REQ-029 MULT, src_a=0xFFFFFFFE, src_b=3 -> next edge HI=0xFFFFFFFF, LO=0xFFFFFFFA; stall never asserted.
REQ-030 MULTU, src_a=src_b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-031 DIV, src_a=0xFFFFFFF9 (-7), src_b=2 -> stall high 33 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-032 DIVU, src_a=100, src_b=7 -> LO=14, HI=2; then MFLO gives hilo_rdata=14 and MFHI gives 2.
REQ-033 DIVU 100/7 with flush pulsed in BUSY cycle 10 -> stall=0 from that cycle, FSM IDLE, HI/LO keep their prior values.
REQ-034 DIV with src_b=0 -> no stall, HI/LO unchanged; DIV with rst pulsed in BUSY cycle 5 -> HI=LO=0, FSM IDLE.
